// File: rtl/sdes_key_sched.sv
// S-DES key schedule: P10 on accept, LS-1/LS-2 rotations and P8 taps yield subkeys k1/k2.
// Optional build macro SDES_KEY_SCHED_DEC_EN adds dec_i, which swaps k1/k2 for decryption.
module sdes_key_sched #(
   parameter bit CLEAR_ON_LOAD = 1'b0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       key_valid_i,
   input  logic [9:0] key_i,
`ifdef SDES_KEY_SCHED_DEC_EN
   input  logic       dec_i,
`endif
   output logic       key_ready_o,
   output logic [7:0] k1_o,
   output logic [7:0] k2_o,
   output logic       keys_valid_o,
   output logic       keys_done_o
);

   localparam int unsigned KEY_W = 10;
   localparam int unsigned SK_W  = 8;

   typedef enum logic [2:0] {IDLE, ROT1, GEN1, ROT2, GEN2} state_e;

   state_e            state_q, state_d;
   logic [KEY_W-1:0]  sr_q, sr_d;
   logic [SK_W-1:0]   k1_q, k1_d;
   logic [SK_W-1:0]   k2_q, k2_d;
   logic              kv_q, kv_d;
   logic              kd_q, kd_d;
`ifdef SDES_KEY_SCHED_DEC_EN
   logic              dec_q, dec_d;
`endif

   // S-DES bit n (1 = MSB) lives at vector index KEY_W-n
   function automatic logic [KEY_W-1:0] p10(input logic [KEY_W-1:0] k);
      return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
   endfunction

   function automatic logic [SK_W-1:0] p8(input logic [KEY_W-1:0] s);
      return {s[4], s[7], s[3], s[6], s[2], s[5], s[0], s[1]};
   endfunction

   function automatic logic [KEY_W-1:0] ls1(input logic [KEY_W-1:0] s);
      return {s[8:5], s[9], s[3:0], s[4]};
   endfunction

   function automatic logic [KEY_W-1:0] ls2(input logic [KEY_W-1:0] s);
      return {s[7:5], s[9:8], s[2:0], s[4:3]};
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         sr_q    <= '0;
         k1_q    <= '0;
         k2_q    <= '0;
         kv_q    <= 1'b0;
         kd_q    <= 1'b0;
`ifdef SDES_KEY_SCHED_DEC_EN
         dec_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         k1_q    <= k1_d;
         k2_q    <= k2_d;
         kv_q    <= kv_d;
         kd_q    <= kd_d;
`ifdef SDES_KEY_SCHED_DEC_EN
         dec_q   <= dec_d;
`endif
      end
   end

   // Next-state and datapath; keys_done defaults low so it is a single-cycle pulse
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      k1_d    = k1_q;
      k2_d    = k2_q;
      kv_d    = kv_q;
      kd_d    = 1'b0;
`ifdef SDES_KEY_SCHED_DEC_EN
      dec_d   = dec_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (key_valid_i) begin
               sr_d    = p10(key_i);
               kv_d    = 1'b0;
               if (CLEAR_ON_LOAD) begin
                  k1_d = '0;
                  k2_d = '0;
               end
`ifdef SDES_KEY_SCHED_DEC_EN
               dec_d   = dec_i;
`endif
               state_d = ROT1;
            end
         end
         ROT1: begin
            sr_d    = ls1(sr_q);
            state_d = GEN1;
         end
         GEN1: begin
`ifdef SDES_KEY_SCHED_DEC_EN
            if (dec_q) k2_d = p8(sr_q);
            else       k1_d = p8(sr_q);
`else
            k1_d    = p8(sr_q);
`endif
            state_d = ROT2;
         end
         ROT2: begin
            sr_d    = ls2(sr_q);
            state_d = GEN2;
         end
         GEN2: begin
`ifdef SDES_KEY_SCHED_DEC_EN
            if (dec_q) k1_d = p8(sr_q);
            else       k2_d = p8(sr_q);
`else
            k2_d    = p8(sr_q);
`endif
            kv_d    = 1'b1;
            kd_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign key_ready_o  = (state_q == IDLE);
   assign k1_o         = k1_q;
   assign k2_o         = k2_q;
   assign keys_valid_o = kv_q;
   assign keys_done_o  = kd_q;

endmodule
